// File: rtl/alu_pipe_core.sv
// alu_pipe_core: pipelined valid/ready ALU with carry/zero/overflow flags,
// sticky overflow status and a wrapping count of delivered results.
module alu_pipe_core #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 3,
  parameter int LATENCY = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [DEPTH-1:0]   opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               carry,
  output logic               zero,
  output logic               overflow,
  input  logic               clr_sticky,
  output logic               sticky_ovf,
  output logic [COUNT_W-1:0] op_count
);
  localparam int SW = $clog2(WIDTH);
  localparam int P  = WIDTH + 4;
  localparam int M  = WIDTH - 1;
  logic [WIDTH:0] sum, dif, shl, shr;
  logic [WIDTH-1:0] r;
  logic c, o, advance, deliver;
  logic [P-1:0] in_word;
  logic [LATENCY-1:0][P-1:0] regs, nxt;
  always_comb begin
    sum = {1'b0, operand_a} + {1'b0, operand_b};
    dif = {1'b0, operand_a} - {1'b0, operand_b};
    // one extra bit on the far side of each shift catches the last bit shifted out
    shl = {1'b0, operand_a} << operand_b[SW-1:0];
    shr = {operand_a, 1'b0} >> operand_b[SW-1:0];
    r = operand_a;
    c = 1'b0;
    o = 1'b0;
    case (opcode)
      DEPTH'(0): begin
        r = sum[M:0];
        c = sum[WIDTH];
        o = (operand_a[M] == operand_b[M]) & (sum[M] != operand_a[M]);
      end
      DEPTH'(1): begin
        r = dif[M:0];
        c = dif[WIDTH];
        o = (operand_a[M] != operand_b[M]) & (dif[M] != operand_a[M]);
      end
      DEPTH'(2): r = operand_a & operand_b;
      DEPTH'(3): r = operand_a | operand_b;
      DEPTH'(4): r = operand_a ^ operand_b;
      DEPTH'(5): {c, r} = shl;
      DEPTH'(6): {r, c} = shr;
      default: ;
    endcase
  end
  assign in_word  = {in_valid, c, r == '0, o, r};
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign deliver  = out_valid & out_ready;
  assign {out_valid, carry, zero, overflow, y} = regs[LATENCY-1];
  if (LATENCY == 1) begin : g_one
    assign nxt = in_word;
  end else begin : g_many
    assign nxt = {regs[LATENCY-2:0], in_word};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs       <= '0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      if (advance) regs <= nxt;
      sticky_ovf <= (deliver & overflow) | (sticky_ovf & !clr_sticky);
      op_count   <= op_count + COUNT_W'(deliver);
    end
  end
endmodule
